nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-word adder that computes `4*NIBBLES`-bit sums by streaming operand nibbles, least-significant first, through one instance of the team's combinational `Adder_4bit`, carrying between nibbles in a register. It sits directly upstream of `Adder_4bit`: it latches wide operands, feeds the adder one nibble per clock, and collects its `S`/`C_out`. A start/busy/done handshake lets a controller request a sum and receive a one-cycle completion pulse. It trades `NIBBLES` cycles of latency for a single 4-bit adder.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; legal range 1..16; `W = 4*NIBBLES`.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  W  operand A; sampled on the accepting edge only.
- `B`  in  W  operand B; sampled on the accepting edge only.
- `C_in`  in  1  carry-in to nibble 0; sampled on the accepting edge only.
- `S`  out  W  sum; valid from the `done` cycle and held until the next accepted start.
- `C_out`  out  1  carry out of the top nibble; same validity as `S`.
- `busy`  out  1  high in ADD and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `V`  out  1  signed overflow; present only with `NIBBLE_SERIAL_ADDER_OVF_EN`.

## Operation
- States:
  - IDLE: `busy=0`, `done=0`.
  - ADD: `busy=1`.
  - DONE: `busy=1`, `done=1`.
- IDLE, `start=1`:
  - Latch `A`, `B` and `C_in` into internal registers.
  - Clear the nibble index to 0 and go to ADD.
  - Clear `S` and `C_out` to 0 on this edge.
- IDLE, `start=0`: stay in IDLE; hold `S` and `C_out`.
- ADD, each cycle:
  - Drive `Adder_4bit` with operand nibble [idx] of A and B and the carry register (which holds `C_in` for idx 0).
  - On the edge, write the adder's `S` into `S[4*idx+3:4*idx]`, load the adder's `C_out` into the carry register, and increment idx.
- ADD, last nibble (`idx = NIBBLES-1`): copy the adder's `C_out` to the `C_out` port and go to DONE.
- DONE: lasts one cycle, then go to IDLE.
- `start` is ignored in ADD and DONE. It is not queued; the requester must re-assert it in IDLE.
- Operand inputs may change freely after the accepting edge without affecting the result.
- Arithmetic: `{C_out,S} = A + B + C_in`, computed modulo 2^(W+1). No saturation.
- `NIBBLES=1` is legal: one ADD cycle.

## Timing
- Reset values: state IDLE, `S=0`, `C_out=0`, `busy=0`, `done=0`, `V=0`, internal registers 0.
- Reset during ADD or DONE aborts the operation immediately. There is no `done` pulse and the partial sum is discarded.
- Edge 0 accepts `start`.
- `busy` rises after edge 0.
- ADD occupies edges 1..NIBBLES.
- `done` is high in the cycle after edge NIBBLES.
- `busy` falls after edge NIBBLES+1.
- Start-to-done latency is `NIBBLES+1` cycles. The earliest next accept is edge `NIBBLES+2`.
- Throughput is one sum per `NIBBLES+2` cycles.
- `S` is partially updated during ADD. Consumers sample it only while `done=1` or later.

## Configuration
- Macro: `NIBBLE_SERIAL_ADDER_OVF_EN`.
- Defined:
  - The `V` port exists.
  - `V = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1])`, using the latched operands and the final sum.
  - `V` is registered on the last ADD edge, valid with `done`, and cleared on an accepted start.
- Undefined: no `V` port and no associated logic. All other behaviour is identical.

## Structure
- Shared package or include holds:
  - the state encoding constants `ST_IDLE`, `ST_ADD`, `ST_DONE` (2-bit);
  - the default `NIBBLES`;
  - the nibble-index width function (`clog2(NIBBLES)`, minimum 1).
- Exactly one sub-module: the existing `Adder_4bit`, instantiated once with explicit port mapping. No other arithmetic is inferred in this block.

## Test plan
All cases use `NIBBLES=4`.
- Basic sum: `A=16'h1234`, `B=16'h0FFF`, `C_in=0`, start for one cycle → `busy` high 5 cycles; `done` exactly 5 cycles after the accepting edge; `S=16'h2233`, `C_out=0`.
- Full carry ripple: `A=16'hFFFF`, `B=16'h0001`, `C_in=0` → `S=16'h0000`, `C_out=1`.
- Maximum inputs: `A=16'hFFFF`, `B=16'hFFFF`, `C_in=1` → `S=16'hFFFF`, `C_out=1`.
- Start while busy: operands `16'h0001+16'h0001`, then `start` held high with `A=16'hAAAA` changed mid-ADD → result `16'h0002`; the second request is taken only if `start` is still high in IDLE.
- Reset mid-operation: assert `nRST=0` during the ADD cycle for nibble 2 → immediate return to IDLE with all outputs 0 and no `done` pulse; a new start then completes normally.
- Overflow (with `NIBBLE_SERIAL_ADDER_OVF_EN`): `16'h7FFF+16'h0001` → `S=16'h8000`, `V=1`; `16'hFFFF+16'h0001` → `V=0`, `C_out=1`.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial multi-word adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the nibble index: clog2(nibbles), never below one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/Adder_4bit.sv
// Combinational 4-bit adder with carry-in and carry-out.
module Adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);

  // Plain 4-bit add, carry appears in bit 4.
  assign {C_out, S} = 5'(A) + 5'(B) + 5'(C_in);

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: streams latched wide operands LSB nibble first
// through a single Adder_4bit, one nibble per clock, with a start/busy/done
// handshake. Optional signed-overflow output V is built when the macro
// NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 C_in,
  output logic [4*NIBBLES-1:0] S,
  output logic                 C_out,
  output logic                 busy,
  output logic                 done
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                 V
`endif
);

  localparam int unsigned IW = idx_width(NIBBLES);

  state_e                    state_q, state_n;
  logic [NIBBLES-1:0][3:0]   a_q, a_n;
  logic [NIBBLES-1:0][3:0]   b_q, b_n;
  logic [NIBBLES-1:0][3:0]   s_q, s_n;
  logic                      carry_q, carry_n;
  logic [IW-1:0]             idx_q, idx_n;
  logic                      cout_q, cout_n;
  logic                      busy_q, busy_n;
  logic                      done_q, done_n;
  logic                      last_nib;
  logic [3:0]                add_s;
  logic                      add_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic                      v_q, v_n;
`endif

  // The only adder in the block; fed with the current nibble pair.
  Adder_4bit u_adder (
    .A     (a_q[idx_q]),
    .B     (b_q[idx_q]),
    .C_in  (carry_q),
    .S     (add_s),
    .C_out (add_co)
  );

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    s_n     = s_q;
    carry_n = carry_q;
    idx_n   = idx_q;
    cout_n  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    v_n     = v_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_n     = A;
          b_n     = B;
          carry_n = C_in;
          idx_n   = '0;
          s_n     = '0;
          cout_n  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          v_n     = 1'b0;
`endif
          state_n = ST_ADD;
        end
      end
      ST_ADD: begin
        s_n[idx_q] = add_s;
        carry_n    = add_co;
        idx_n      = idx_q + IW'(1);
        if (last_nib) begin
          cout_n  = add_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          v_n     = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                    (add_s[3] != a_q[NIBBLES-1][3]);
`endif
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      s_q     <= s_n;
      carry_q <= carry_n;
      idx_q   <= idx_n;
      cout_q  <= cout_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      v_q     <= v_n;
`endif
    end
  end

  assign S     = s_q;
  assign C_out = cout_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign V     = v_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with NIBBLES=4: directed
// table, handshake corner cases, reset abort and random sums checked
// against a plain-arithmetic reference.
module tb_nibble_serial_adder;

  localparam int N = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_co;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic [15:0] S;
  logic        C_out;
  logic        busy;
  logic        done;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        V;
`endif

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out),
    .busy  (busy),
    .done  (done)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .V     (V)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one sum and check the whole handshake plus the result against A+B+C_in.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
    logic [16:0] ref_sum;
    logic        ref_v;
    ref_sum = {1'b0, a} + {1'b0, b} + 17'(cin);
    ref_v   = (a[15] == b[15]) && (ref_sum[15] != a[15]);
    @(negedge CLK);
    A = a; B = b; C_in = cin; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    A = 16'($urandom()); B = 16'($urandom()); C_in = 1'($urandom_range(0, 1));
    chk({tag, ".acc_busy"}, 32'(busy), 32'd1);
    chk({tag, ".acc_done"}, 32'(done), 32'd0);
    chk({tag, ".acc_S"}, 32'(S), 32'd0);
    for (int e = 1; e <= N + 1; e++) begin
      @(posedge CLK); #1;
      chk({tag, ".busy"}, 32'(busy), 32'(e <= N));
      chk({tag, ".done"}, 32'(done), 32'(e == N));
      if (e >= N) begin
        chk({tag, ".S"}, 32'(S), 32'(ref_sum[15:0]));
        chk({tag, ".C_out"}, 32'(C_out), 32'(ref_sum[16]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk({tag, ".V"}, 32'(V), 32'(ref_v));
`endif
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   done_seen;
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    nRST = 1'b0; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.S", 32'(S), 32'd0);
    chk("rst.C_out", 32'(C_out), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("rst.V", 32'(V), 32'd0);
`endif
    @(negedge CLK); nRST = 1'b1;

    // Directed table: table results checked explicitly, handshake in run_op.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("vec%0d.tbl_S", i), 32'(S), 32'(vecs[i].exp_s));
      chk($sformatf("vec%0d.tbl_C_out", i), 32'(C_out), 32'(vecs[i].exp_co));
    end

    // Start held high across a busy operation, operand changed mid-ADD.
    @(negedge CLK);
    A = 16'h0001; B = 16'h0001; C_in = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    for (int e = 1; e <= N; e++) begin
      @(posedge CLK); #1;
      if (e == 1) A = 16'hAAAA;
    end
    chk("hold.done", 32'(done), 32'd1);
    chk("hold.S", 32'(S), 32'h0002);
    chk("hold.C_out", 32'(C_out), 32'd0);
    @(posedge CLK); #1;
    chk("hold.idle_busy", 32'(busy), 32'd0);
    chk("hold.idle_S", 32'(S), 32'h0002);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("hold.reacc_busy", 32'(busy), 32'd1);
    chk("hold.reacc_S", 32'(S), 32'd0);
    repeat (N) @(posedge CLK);
    #1;
    chk("hold.second_done", 32'(done), 32'd1);
    chk("hold.second_S", 32'(S), 32'hAAAB);
    @(posedge CLK); #1;

    // Reset during the ADD cycle for nibble 2 aborts with no done pulse.
    @(negedge CLK);
    A = 16'h9999; B = 16'h8888; C_in = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("abort.S", 32'(S), 32'd0);
    chk("abort.C_out", 32'(C_out), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("abort.V", 32'(V), 32'd0);
`endif
    @(negedge CLK); nRST = 1'b1;
    done_seen = 0;
    for (int e = 0; e < N + 3; e++) begin
      @(posedge CLK); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("abort.no_done", 32'(done_seen), 32'd0);
    run_op("after_abort", 16'h1111, 16'h2222, 1'b1);

    // Random sums against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 16'($urandom()), 16'($urandom()),
             1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
